dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: single-outstanding data-memory responder with a fixed      |
// | request-to-response latency, sized stores/loads and request fault checks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic        b_e,
    input  logic        h_e,
    input  logic        w_e,
    input  logic [31:0] wdata_w,
    input  logic [15:0] wdata_h,
    input  logic [7:0]  wdata_b,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int unsigned c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        be_q, be_d;
    logic        he_q, he_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic              w_accept;
    logic              w_enter_resp;
    logic [31:0]       w_live_wdata;
    logic [31:0]       w_src_addr;
    logic              w_src_wr, w_src_be, w_src_he, w_src_we;
    logic [31:0]       w_src_wdata;
    logic [1:0]        w_size_cnt;
    logic              w_fault;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_rd;
    logic [31:0]       w_mask;
    logic [31:0]       w_repl;
    logic [31:0]       w_merged;
    logic              w_commit;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    assign w_live_wdata = w_e ? wdata_w : (h_e ? {16'b0, wdata_h} : {24'b0, wdata_b});

    // With LATENCY=1 the edge entering RESP is the accepting edge itself, so the
    // request is taken straight from the inputs; otherwise from the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            w_src_addr  = addr;
            w_src_wr    = wr;
            w_src_be    = b_e;
            w_src_he    = h_e;
            w_src_we    = w_e;
            w_src_wdata = w_live_wdata;
        end else begin
            w_src_addr  = addr_q;
            w_src_wr    = wr_q;
            w_src_be    = be_q;
            w_src_he    = he_q;
            w_src_we    = we_q;
            w_src_wdata = wdata_q;
        end
    end

    assign w_size_cnt = {1'b0, w_src_be} + {1'b0, w_src_he} + {1'b0, w_src_we};
    assign w_fault    = (w_size_cnt != 2'd1)
                     || (w_src_he && w_src_addr[0])
                     || (w_src_we && (w_src_addr[1:0] != 2'b00))
                     || ((w_src_addr >> (c_IDX_W + 2)) != 32'd0);

    assign w_idx  = w_src_addr[c_IDX_W+1:2];
    assign w_word = mem_q[w_idx];

    always_comb begin
        if (w_src_we) begin
            w_rd   = w_word;
            w_mask = 32'hFFFF_FFFF;
            w_repl = w_src_wdata;
        end else if (w_src_he) begin
            w_rd   = {16'b0, w_word[{w_src_addr[1], 4'b0000} +: 16]};
            w_mask = 32'h0000_FFFF << {w_src_addr[1], 4'b0000};
            w_repl = {2{w_src_wdata[15:0]}};
        end else begin
            w_rd   = {24'b0, w_word[{w_src_addr[1:0], 3'b000} +: 8]};
            w_mask = 32'h0000_00FF << {w_src_addr[1:0], 3'b000};
            w_repl = {4{w_src_wdata[7:0]}};
        end
    end

    assign w_merged = (w_word & ~w_mask) | (w_repl & w_mask);
    assign w_commit = w_enter_resp && w_src_wr && !w_fault && !rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        be_d         = be_q;
        he_d         = he_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        w_enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    be_d    = b_e;
                    he_d    = h_e;
                    we_d    = w_e;
                    wdata_d = w_live_wdata;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_enter_resp) begin
            rsp_valid_d = 1'b1;
            fault_d     = w_fault;
            rdata_d     = (w_fault || w_src_wr) ? 32'd0 : w_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wr_q        <= 1'b0;
            be_q        <= 1'b0;
            he_q        <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            he_q        <= he_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem_q[w_idx] <= w_merged;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_responder: directed and random checks of dmem_responder at         |
// | LATENCY=2 and LATENCY=1 against a byte-lane memory model.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_valid1;
    logic [31:0] addr;
    logic        wr, b_e, h_e, w_e;
    logic [31:0] wdata_w;
    logic [15:0] wdata_h;
    logic [7:0]  wdata_b;
    logic        ready0, rsp0, fault0;
    logic [31:0] rdata0;
    logic        ready1, rsp1, fault1;
    logic [31:0] rdata1;

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [256];
    logic [31:0] last_d0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
        .addr(addr), .wr(wr), .b_e(b_e), .h_e(h_e), .w_e(w_e),
        .wdata_w(wdata_w), .wdata_h(wdata_h), .wdata_b(wdata_b),
        .rsp_valid(rsp0), .rdata(rdata0), .fault(fault0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(ready1),
        .addr(addr), .wr(wr), .b_e(b_e), .h_e(h_e), .w_e(w_e),
        .wdata_w(wdata_w), .wdata_h(wdata_h), .wdata_b(wdata_b),
        .rsp_valid(rsp1), .rdata(rdata1), .fault(fault1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit f_fault(input logic [31:0] a, input bit b, input bit h, input bit w);
        int n;
        n = int'(b) + int'(h) + int'(w);
        return (n != 1) || (h && (a % 2 != 0)) || (w && (a % 4 != 0)) || ((a / 4) >= 256);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] a, input bit b, input bit h);
        logic [31:0] word;
        word = mdl[a / 4];
        if (b) return (word >> (8 * (a % 4))) & 32'h0000_00FF;
        if (h) return (word >> (8 * (a % 4))) & 32'h0000_FFFF;
        return word;
    endfunction

    task automatic m_store(input logic [31:0] a, input bit b, input bit h,
                           input logic [31:0] d32, input logic [15:0] d16, input logic [7:0] d8);
        logic [7:0] bytes [4];
        int lane;
        for (int i = 0; i < 4; i++) bytes[i] = mdl[a / 4][8*i +: 8];
        lane = int'(a % 4);
        if (b) begin
            bytes[lane] = d8;
        end else if (h) begin
            bytes[lane]     = d16[7:0];
            bytes[lane + 1] = d16[15:8];
        end else begin
            for (int i = 0; i < 4; i++) bytes[i] = d32[8*i +: 8];
        end
        mdl[a / 4] = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endtask

    // One request to both instances; called and returns just after a falling edge.
    task automatic txn(input bit w_r, input bit b, input bit h, input bit w, input logic [31:0] a,
                       input logic [31:0] d32, input logic [15:0] d16, input logic [7:0] d8,
                       input string tag);
        bit          ef;
        logic [31:0] ed;
        int          n0, n1, l0, l1;
        logic [31:0] dd0, dd1;
        logic        ff0, ff1;
        ef = f_fault(a, b, h, w);
        ed = (ef || w_r) ? 32'd0 : f_load(a, b, h);
        if (!ef && w_r) m_store(a, b, h, d32, d16, d8);
        check({tag, "_rdy0"}, 32'(ready0), 32'd1);
        check({tag, "_rdy1"}, 32'(ready1), 32'd1);
        addr = a; wr = w_r; b_e = b; h_e = h; w_e = w;
        wdata_w = d32; wdata_h = d16; wdata_b = d8;
        req_valid = 1'b1; req_valid1 = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_valid1 = 1'b0;
        addr = $urandom; wr = 1'($urandom); b_e = 1'($urandom); h_e = 1'($urandom);
        w_e = 1'($urandom); wdata_w = $urandom; wdata_h = 16'($urandom); wdata_b = 8'($urandom);
        n0 = 0; n1 = 0; l0 = 0; l1 = 0;
        dd0 = 32'hx; dd1 = 32'hx; ff0 = 1'bx; ff1 = 1'bx;
        for (int k = 1; k <= 3; k++) begin
            if (rsp0) begin n0++; l0 = k; dd0 = rdata0; ff0 = fault0; end
            if (rsp1) begin n1++; l1 = k; dd1 = rdata1; ff1 = fault1; end
            @(negedge clk);
        end
        last_d0 = dd0;
        check({tag, "_n0"}, 32'(n0), 32'd1);
        check({tag, "_lat0"}, 32'(l0), 32'd2);
        check({tag, "_data0"}, dd0, ed);
        check({tag, "_fault0"}, 32'(ff0), 32'(ef));
        check({tag, "_n1"}, 32'(n1), 32'd1);
        check({tag, "_lat1"}, 32'(l1), 32'd1);
        check({tag, "_data1"}, dd1, ed);
        check({tag, "_fault1"}, 32'(ff1), 32'(ef));
    endtask

    initial begin
        bit          acc [16];
        logic [31:0] expd [16];
        logic [31:0] a;
        bit          exp_ready, exp_rsp, b, h, w;
        int          sel;

        rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0;
        addr = 32'd0; wr = 1'b0; b_e = 1'b0; h_e = 1'b0; w_e = 1'b0;
        wdata_w = 32'd0; wdata_h = 16'd0; wdata_b = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(ready0), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd0);
        check("rst_rsp0", 32'(rsp0), 32'd0);
        check("rst_fault0", 32'(fault0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready0", 32'(ready0), 32'd1);

        for (int i = 0; i < 9; i++)
            txn(1'b1, 1'b0, 1'b0, 1'b1, 32'(4 * i), $urandom, 16'd0, 8'd0, "init");

        txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 16'd0, 8'd0, "st_w10");
        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 16'd0, 8'd0, "ld_w10");
        check("ld_w10_const", last_d0, 32'hDEADBEEF);
        txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'd0, 16'd0, 8'h55, "st_b12");
        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 16'd0, 8'd0, "ld_w10b");
        check("ld_w10b_const", last_d0, 32'hDE55BEEF);
        txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h12, 32'd0, 16'd0, 8'd0, "ld_h12");
        check("ld_h12_const", last_d0, 32'h0000DE55);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'd0, 16'd0, 8'd0, "ld_b13");
        check("ld_b13_const", last_d0, 32'h000000DE);

        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 32'd0, 16'd0, 8'd0, "flt_w11");
        txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 16'hAAAA, 8'd0, "flt_h13");
        txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 16'hBBBB, 8'hCC, "flt_bh");
        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'd0, 16'd0, 8'd0, "flt_oor");
        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 16'd0, 8'd0, "ld_w10c");
        check("ld_w10c_const", last_d0, 32'hDE55BEEF);

        // Continuous req_valid on the LATENCY=2 instance; garbage stores while busy.
        for (int c = 0; c < 12; c++) begin
            exp_ready = !((c >= 1 && acc[c-1]) || (c >= 2 && acc[c-2]));
            exp_rsp   = (c >= 2) && acc[c-2];
            check("hs_ready", 32'(ready0), 32'(exp_ready));
            check("hs_rsp", 32'(rsp0), 32'(exp_rsp));
            if (exp_rsp) check("hs_rdata", rdata0, expd[c-2]);
            req_valid = 1'b1;
            if (exp_ready) begin
                a = 32'(4 * $urandom_range(0, 7));
                addr = a; wr = 1'b0; b_e = 1'b0; h_e = 1'b0; w_e = 1'b1;
                acc[c] = 1'b1; expd[c] = mdl[a / 4];
            end else begin
                addr = 32'(4 * $urandom_range(0, 7)); wr = 1'b1;
                b_e = 1'b0; h_e = 1'b0; w_e = 1'b1; wdata_w = $urandom;
                acc[c] = 1'b0; expd[c] = 32'd0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        // Reset during WAIT of a store to 0x20.
        check("rs_ready_pre", 32'(ready0), 32'd1);
        addr = 32'h20; wr = 1'b1; b_e = 1'b0; h_e = 1'b0; w_e = 1'b1; wdata_w = 32'h12345678;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rs_ready_wait", 32'(ready0), 32'd0);
        rst = 1'b1;
        #1;
        check("rs_ready_in_rst", 32'(ready0), 32'd0);
        check("rs_rsp_in_rst", 32'(rsp0), 32'd0);
        @(negedge clk);
        check("rs_rdata_in_rst", rdata0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rs_ready_post", 32'(ready0), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("rs_no_rsp", 32'(rsp0), 32'd0);
            @(negedge clk);
        end
        txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'd0, 16'd0, 8'd0, "rs_ld20");

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            b = (sel <= 2); h = (sel >= 3 && sel <= 5); w = (sel >= 6 && sel <= 8);
            if (sel == 9) begin b = 1'($urandom); h = 1'($urandom); w = 1'($urandom); end
            a = ($urandom_range(0, 7) == 0) ? (32'h400 + $urandom_range(0, 1023))
                                             : 32'($urandom_range(0, 31));
            txn(1'($urandom), b, h, w, a, $urandom, 16'($urandom), 8'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
